frame_update_scheduler: RTL

//  Sequences once-per-frame game updates (input sample, Mario move, Goomba move, collision) during VGA vertical blanking.

---
 rtl/game_pkg.sv | 34 +++
 rtl/frame_update_scheduler_if.sv | 11 +
 rtl/frame_update_scheduler_button_edge_sync.sv | 26 ++
 rtl/frame_update_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types, screen geometry and tile codes for the frame update scheduler
// and the tile-map game logic around it.
package game_pkg;

    typedef enum logic [1:0] {
        GS_TITLE = 2'd0,
        GS_PLAY  = 2'd1,
        GS_OVER  = 2'd2,
        GS_WIN   = 2'd3
    } game_state_t;

    typedef enum logic {
        SQ_IDLE = 1'b0,
        SQ_RUN  = 1'b1
    } sched_state_t;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    // Tile-map codes shared with the renderer and collision unit
    localparam logic [3:0] BDR = 4'd0;
    localparam logic [3:0] SKY = 4'd1;
    localparam logic [3:0] GND = 4'd2;
    localparam logic [3:0] BRK = 4'd3;
    localparam logic [3:0] QBK = 4'd4;
    localparam logic [3:0] PIP = 4'd5;
    localparam logic [3:0] CK1 = 4'd6;
    localparam logic [3:0] CK2 = 4'd7;

    function automatic logic [31:0] sat_dec(input logic [31:0] value);
        sat_dec = (value == 32'd0) ? 32'd0 : value - 32'd1;
    endfunction

endpackage

// File: rtl/frame_update_scheduler_if.sv
// Phase request/done handshake between the frame scheduler (master) and the update units (slave).
interface frame_update_scheduler_if #(
    parameter int NUM_PHASES = 4
);
    logic [NUM_PHASES-1:0] phase_req;
    logic [NUM_PHASES-1:0] phase_done;
    logic                  frame_done;

    modport master (output phase_req, output frame_done, input phase_done);
    modport slave  (input phase_req, input frame_done, output phase_done);
endinterface

// File: rtl/frame_update_scheduler_button_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge detector for a raw push button.
module button_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pulse
);
    logic [1:0] sync_r;
    logic       prev_r;
    logic       pulse_r;

    // Synchronise, then emit one pulse per press however long it is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r  <= 2'b00;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], button};
            prev_r  <= sync_r[1];
            pulse_r <= sync_r[1] & ~prev_r;
        end
    end

    assign pulse = pulse_r;
endmodule

// File: rtl/frame_update_scheduler.sv
// Once-per-frame update sequencer run in vertical blanking, plus game state and seconds timer.
// Optional feature macro: FRAME_SCHED_PAUSE_EN (adds pause_button and a paused state in PLAY).
module frame_update_scheduler
    import game_pkg::*;
#(
    parameter int SCREEN_HEIGHT     = 480,
    parameter int NUM_PHASES        = 4,
    parameter int FRAMES_PER_SECOND = 60,
    parameter int TIME_LIMIT        = 300,
    parameter int PHASE_TIMEOUT     = 1024
) (
    input  logic                      vga_clock,
    input  logic                      reset,
    input  logic [31:0]               row,
    input  logic [31:0]               column,
    input  logic                      start_button,
`ifdef FRAME_SCHED_PAUSE_EN
    input  logic                      pause_button,
`endif
    input  logic                      mario_dead,
    input  logic                      level_done,
    frame_update_scheduler_if.master  bus,
    output game_state_t               game_state,
    output logic [31:0]               seconds,
    output logic                      overrun
);
    localparam int PH_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int TMO_W = (PHASE_TIMEOUT > 1) ? $clog2(PHASE_TIMEOUT) : 1;
    localparam int FPS_W = (FRAMES_PER_SECOND > 1) ? $clog2(FRAMES_PER_SECOND) : 1;

    logic                  tick_r;
    logic                  start_pulse_s;
    logic                  paused_s;
    sched_state_t          sq_state_r;
    logic [PH_W-1:0]       phase_idx_r;
    logic [TMO_W-1:0]      tmo_cnt_r;
    logic [NUM_PHASES-1:0] phase_req_r;
    logic                  frame_done_r;
    game_state_t           gs_r;
    game_state_t           gs_next_s;
    logic [FPS_W-1:0]      frame_cnt_r;
    logic [31:0]           seconds_r;
    logic                  overrun_r;
    logic                  tick_eff_s;
    logic                  cur_done_s;
    logic                  timeout_s;
    logic                  advance_s;
    logic                  last_phase_s;
    logic                  seq_err_s;
    logic                  count_frame_s;
    logic                  wrap_s;
    logic                  play_entry_s;

    button_edge_sync u_start_sync (
        .clk    (vga_clock),
        .rst    (reset),
        .button (start_button),
        .pulse  (start_pulse_s)
    );

`ifdef FRAME_SCHED_PAUSE_EN
    logic pause_pulse_s;
    logic paused_r;

    button_edge_sync u_pause_sync (
        .clk    (vga_clock),
        .rst    (reset),
        .button (pause_button),
        .pulse  (pause_pulse_s)
    );

    // Pause toggles only inside PLAY and never survives leaving it
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            paused_r <= 1'b0;
        end else if (gs_next_s != GS_PLAY) begin
            paused_r <= 1'b0;
        end else if (pause_pulse_s && (gs_r == GS_PLAY)) begin
            paused_r <= ~paused_r;
        end else begin
            paused_r <= paused_r;
        end
    end

    assign paused_s = paused_r;
`else
    assign paused_s = 1'b0;
`endif

    // Frame tick: first blanking row, column 0, one cycle late
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= (row == 32'(SCREEN_HEIGHT)) && (column == 32'd0);
        end
    end

    // Sequencer and game-state decode
    always_comb begin
        tick_eff_s   = tick_r & ~paused_s;
        cur_done_s   = bus.phase_done[phase_idx_r];
        last_phase_s = (phase_idx_r == PH_W'(NUM_PHASES - 1));
        timeout_s    = 1'b0;
        advance_s    = 1'b0;
        if (sq_state_r == SQ_RUN) begin
            timeout_s = ~cur_done_s && (tmo_cnt_r == TMO_W'(PHASE_TIMEOUT - 1));
            advance_s = cur_done_s | timeout_s;
        end else begin
            timeout_s = 1'b0;
            advance_s = 1'b0;
        end
        seq_err_s     = (sq_state_r == SQ_RUN) && (tick_eff_s || timeout_s);
        count_frame_s = frame_done_r && (gs_r == GS_PLAY) && !paused_s;
        wrap_s        = count_frame_s && (frame_cnt_r == FPS_W'(FRAMES_PER_SECOND - 1));
        play_entry_s  = (gs_r == GS_TITLE) && start_pulse_s;
        gs_next_s     = gs_r;
        case (gs_r)
            GS_TITLE: begin
                if (start_pulse_s) gs_next_s = GS_PLAY;
                else               gs_next_s = GS_TITLE;
            end
            GS_PLAY: begin
                if (paused_s)                                                  gs_next_s = GS_PLAY;
                else if (mario_dead || (wrap_s && sat_dec(seconds_r) == 32'd0)) gs_next_s = GS_OVER;
                else if (level_done)                                           gs_next_s = GS_WIN;
                else                                                           gs_next_s = GS_PLAY;
            end
            GS_OVER, GS_WIN: begin
                if (start_pulse_s) gs_next_s = GS_TITLE;
                else               gs_next_s = gs_r;
            end
            default: gs_next_s = GS_TITLE;
        endcase
    end

    // Phase sequencer: one-hot request walks the phases with no idle gap between them
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            sq_state_r   <= SQ_IDLE;
            phase_idx_r  <= {PH_W{1'b0}};
            tmo_cnt_r    <= {TMO_W{1'b0}};
            phase_req_r  <= {NUM_PHASES{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (sq_state_r)
                SQ_IDLE: begin
                    phase_idx_r <= {PH_W{1'b0}};
                    tmo_cnt_r   <= {TMO_W{1'b0}};
                    if (tick_eff_s && (gs_r == GS_PLAY)) begin
                        sq_state_r  <= SQ_RUN;
                        phase_req_r <= NUM_PHASES'(1);
                    end else begin
                        phase_req_r <= {NUM_PHASES{1'b0}};
                    end
                end
                SQ_RUN: begin
                    if (!advance_s) begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end else if (last_phase_s) begin
                        tmo_cnt_r    <= {TMO_W{1'b0}};
                        sq_state_r   <= SQ_IDLE;
                        phase_idx_r  <= {PH_W{1'b0}};
                        phase_req_r  <= {NUM_PHASES{1'b0}};
                        frame_done_r <= 1'b1;
                    end else begin
                        tmo_cnt_r   <= {TMO_W{1'b0}};
                        phase_idx_r <= phase_idx_r + PH_W'(1);
                        phase_req_r <= phase_req_r << 1;
                    end
                end
                default: begin
                    sq_state_r  <= SQ_IDLE;
                    phase_req_r <= {NUM_PHASES{1'b0}};
                end
            endcase
        end
    end

    // Game state, seconds countdown and sticky overrun
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            gs_r        <= GS_TITLE;
            seconds_r   <= 32'(TIME_LIMIT);
            frame_cnt_r <= {FPS_W{1'b0}};
            overrun_r   <= 1'b0;
        end else begin
            gs_r <= gs_next_s;
            if (play_entry_s) begin
                seconds_r   <= 32'(TIME_LIMIT);
                frame_cnt_r <= {FPS_W{1'b0}};
                overrun_r   <= 1'b0;
            end else begin
                if (wrap_s) begin
                    frame_cnt_r <= {FPS_W{1'b0}};
                    seconds_r   <= sat_dec(seconds_r);
                end else if (count_frame_s) begin
                    frame_cnt_r <= frame_cnt_r + FPS_W'(1);
                end else begin
                    frame_cnt_r <= frame_cnt_r;
                end
                if (seq_err_s) overrun_r <= 1'b1;
                else           overrun_r <= overrun_r;
            end
        end
    end

    assign bus.phase_req  = phase_req_r;
    assign bus.frame_done = frame_done_r;
    assign game_state     = gs_r;
    assign seconds        = seconds_r;
    assign overrun        = overrun_r;
endmodule
